seq_step_ctrl: RTL and testbench
================================

Name: seq_step_ctrl

Overview:
- Controller that drives the step input (x) of a 2-bit sequence register and walks it to a requested target code.
- Holds the sequence register internally; exposes its value on count.
- Two sequence orders are supported, selected per request.
- Used wherever a sequence FSM must be positioned to a known code under a simple req/done handshake, instead of hand-toggling x from a bench.

Parameters:
- SEQ_A_INIT, 2'b00, count value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on posedge clk
- rst  input  1  asynchronous active-low reset
- req  input  1  request strobe; sampled only in IDLE
- target  input  2  requested code; latched when req is accepted
- mode  input  1  sequence select (0 = order A, 1 = order B); latched with target
- busy  output  1  high in STEP and DONE
- done  output  1  one-cycle pulse when count equals the latched target
- step  output  1  step strobe to the sequence register (the x line); high only in STEP
- count  output  2  current sequence register value
- steps_taken  output  2  number of steps used by the last or current request, 0..3

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, count = SEQ_A_INIT.
  - tgt_q = 0, mode_q = 0, steps_taken = 0.
  - busy = 0, done = 0, step = 0.
- Sequence register, advancing on posedge clk when step = 1, holding otherwise:
  - Order A: 00 -> 10 -> 11 -> 01 -> 00.
  - Order B: 00 -> 11 -> 10 -> 01 -> 00.
  - Both orders wrap modulo 4. Any target is reached in at most 3 steps.
- FSM states: IDLE, STEP, DONE. All outputs are Moore (state-registered).
  - step = (state == STEP)
  - busy = (state != IDLE)
  - done = (state == DONE)
- IDLE, req = 1 at edge E0:
  - Latch tgt_q = target and mode_q = mode; clear steps_taken.
  - If count == target: go to DONE (zero-step request).
  - Otherwise: go to STEP.
- STEP, each edge:
  - count advances per mode_q; steps_taken increments.
  - If the next count equals tgt_q, go to DONE; otherwise stay in STEP.
- DONE: unconditionally return to IDLE on the next edge.
- Latency for a distance of d steps:
  - step is high for exactly d cycles (E0..Ed).
  - done is high in the cycle after Ed; IDLE is re-entered at Ed+1.
  - For d = 0, done is high in the cycle after E0.
- Handshake rules:
  - req is ignored while busy; no queuing.
  - req held high continuously retriggers a new request in the first IDLE cycle after DONE.
  - target and mode changes while busy have no effect; the latched copies are used.
- steps_taken holds its value after done until the next accepted req.
- Reset asserted mid-operation: immediately return to the reset values; any partial stepping is lost; done is not produced.
- Simultaneous req and reset release at the same edge: reset wins, and req is not sampled on that edge.

Optional Feature:
- Macro: SEQ_STEP_ABORT_EN.
- With the macro defined:
  - Extra input port abort (1 bit).
  - abort = 1 in STEP forces state to DONE at the next edge with no count advance on that edge.
  - done still pulses; steps_taken reflects the steps actually taken.
  - abort is ignored in IDLE and DONE.
- Without the macro: no abort port, and every request runs to its target.

Decomposition:
- Shared package seq_step_pkg holds:
  - State encoding constants: IDLE = 2'b00, STEP = 2'b01, DONE = 2'b10.
  - Sequence code constants S0..S3 = 2'b00..2'b11.
  - Function next_code(code, mode) returning the successor for order A or B.
- One natural sub-module, seq_step_reg: the 2-bit sequence register.
  - Inputs: clk, rst, step, mode_q.
  - Output: count.
  - The controller instantiates it and drives step.

Test Plan:
- Reset, then req with target = 10, mode = 0 -> step high 1 cycle, count = 10, done pulse, steps_taken = 1, busy low afterwards.
- From count = 00, req with target = 01, mode = 0 -> step high 3 cycles, count goes 10, 11, 01, done pulse, steps_taken = 3.
- From count = 00, req with target = 10, mode = 1 -> count goes 11, 10, steps_taken = 2; then req with target = 10 -> zero-step done one cycle after req, step never high.
- req held high, with target toggled while busy -> the first request completes to its original target, a second request starts the cycle after DONE, and the toggled target is ignored until accepted.
- Pull rst low while in STEP with count = 11 -> count = 00, busy = 0, done = 0 immediately, with no done pulse after release.
- With SEQ_STEP_ABORT_EN: target = 01, mode = 0, abort asserted on the 2nd STEP cycle -> count = 10, steps_taken = 1, done pulses, return to IDLE.

Source files
------------

// File: rtl/seq_step_ctrl_pkg.sv
// seq_step_pkg: shared types, codes and sequence successor function for the
// sequence-step controller. No configuration macros are used in this file.
package seq_step_pkg;

  // Controller state encoding; the values are fixed so waveforms decode consistently
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    STEP = 2'b01,
    DONE = 2'b10
  } state_e;

  // Sequence register codes
  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

  // Sequence order select values
  localparam logic MODE_A = 1'b0;
  localparam logic MODE_B = 1'b1;

  // Successor of a code in the selected order.
  // Order A: 00 -> 10 -> 11 -> 01 -> 00
  // Order B: 00 -> 11 -> 10 -> 01 -> 00
  function automatic logic [1:0] next_code(input logic [1:0] code, input logic mode);
    logic [1:0] nxt;
    nxt = S0;
    if (mode == MODE_A) begin
      case (code)
        S0:      nxt = S2;
        S2:      nxt = S3;
        S3:      nxt = S1;
        default: nxt = S0;
      endcase
    end else begin
      case (code)
        S0:      nxt = S3;
        S3:      nxt = S2;
        S2:      nxt = S1;
        default: nxt = S0;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/seq_step_ctrl_if.sv
// seq_step_ctrl_if: request/status bundle of the sequence-step controller.
// Macro SEQ_STEP_ABORT_EN adds the abort request line.
interface seq_step_ctrl_if;

  logic       req;
  logic [1:0] target;
  logic       mode;
`ifdef SEQ_STEP_ABORT_EN
  logic       abort;
`endif
  logic       busy;
  logic       done;
  logic       step;
  logic [1:0] count;
  logic [1:0] steps_taken;

  // Requester side: issues requests, observes progress
  modport master (
    output req,
    output target,
    output mode,
`ifdef SEQ_STEP_ABORT_EN
    output abort,
`endif
    input  busy,
    input  done,
    input  step,
    input  count,
    input  steps_taken
  );

  // Controller side
  modport slave (
    input  req,
    input  target,
    input  mode,
`ifdef SEQ_STEP_ABORT_EN
    input  abort,
`endif
    output busy,
    output done,
    output step,
    output count,
    output steps_taken
  );

endinterface

// File: rtl/seq_step_ctrl_reg.sv
// seq_step_reg: the 2-bit sequence register. It advances one code along the
// order selected by mode_q on every clock where step is high.
// No configuration macros are used in this file.
module seq_step_reg #(
  parameter logic [1:0] SEQ_A_INIT = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       mode_q,
  output logic [1:0] count
);
  import seq_step_pkg::*;

  logic [1:0] r_count;

  // Advance the code on a step strobe, otherwise hold; reset loads the initial code
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= SEQ_A_INIT;
    end else if (step) begin
      r_count <= next_code(r_count, mode_q);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/seq_step_ctrl.sv
// seq_step_ctrl: walks an internal 2-bit sequence register to a requested
// target code under a req/done handshake, in order A or order B.
// Optional macro SEQ_STEP_ABORT_EN adds an abort input that ends stepping early.
module seq_step_ctrl #(
  parameter logic [1:0] SEQ_A_INIT = 2'b00
) (
  input  logic           clk,
  input  logic           rst,
  seq_step_ctrl_if.slave bus
);
  import seq_step_pkg::*;

  state_e     r_state;
  state_e     w_stateNext;
  logic [1:0] r_tgtQ;
  logic       r_modeQ;
  logic [1:0] r_stepsTaken;

  logic [1:0] w_count;
  logic [1:0] w_nextCode;
  logic       w_accept;
  logic       w_advance;
  logic       w_abort;

`ifdef SEQ_STEP_ABORT_EN
  assign w_abort = bus.abort && (r_state == STEP);
`else
  assign w_abort = 1'b0;
`endif

  // A request is only taken in IDLE; while busy it is simply not looked at
  assign w_accept   = (r_state == IDLE) && bus.req;
  // An abort cycle still shows step high but must not move the register
  assign w_advance  = (r_state == STEP) && !w_abort;
  assign w_nextCode = next_code(w_count, r_modeQ);

  seq_step_reg #(
    .SEQ_A_INIT (SEQ_A_INIT)
  ) u_seqReg (
    .clk    (clk),
    .rst    (rst),
    .step   (w_advance),
    .mode_q (r_modeQ),
    .count  (w_count)
  );

  // Next-state decision: finish as soon as the code about to be loaded is the target
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (bus.req) begin
          if (w_count == bus.target) begin
            w_stateNext = DONE;
          end else begin
            w_stateNext = STEP;
          end
        end
      end
      STEP: begin
        if (w_abort) begin
          w_stateNext = DONE;
        end else if (w_nextCode == r_tgtQ) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Capture target and order at acceptance so later input changes cannot disturb a run
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tgtQ  <= S0;
      r_modeQ <= MODE_A;
    end else if (w_accept) begin
      r_tgtQ  <= bus.target;
      r_modeQ <= bus.mode;
    end
  end

  // Count steps actually taken; the value stays visible until the next accepted request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stepsTaken <= 2'd0;
    end else if (w_accept) begin
      r_stepsTaken <= 2'd0;
    end else if (w_advance) begin
      r_stepsTaken <= r_stepsTaken + 2'd1;
    end
  end

  assign bus.step        = (r_state == STEP);
  assign bus.busy        = (r_state != IDLE);
  assign bus.done        = (r_state == DONE);
  assign bus.count       = w_count;
  assign bus.steps_taken = r_stepsTaken;

endmodule

// File: tb/tb_seq_step_ctrl.sv
// tb_seq_step_ctrl: directed bench for seq_step_ctrl. Inputs change and outputs
// are sampled on the falling clock edge. Covers the abort input when
// SEQ_STEP_ABORT_EN is defined.
module tb_seq_step_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_step_ctrl_if bus ();

  seq_step_ctrl #(
    .SEQ_A_INIT (2'b00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive the request inputs for the next rising edge
  task automatic applyStimulus(input logic req, input logic [1:0] target, input logic mode);
    bus.req    = req;
    bus.target = target;
    bus.mode   = mode;
  endtask

  // Let one rising edge pass and stop on the following falling edge
  task automatic waitCycle();
    @(negedge clk);
  endtask

  // Pulse reset low for one cycle away from the rising edge
  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0);
`ifdef SEQ_STEP_ABORT_EN
    bus.abort = 1'b0;
`endif

    // Reset state
    waitCycle();
    waitCycle();
    checkOutput("rst_count", {2'b0, bus.count}, 4'h0);
    checkOutput("rst_busy", {3'b0, bus.busy}, 4'h0);
    checkOutput("rst_done", {3'b0, bus.done}, 4'h0);
    checkOutput("rst_step", {3'b0, bus.step}, 4'h0);
    checkOutput("rst_steps", {2'b0, bus.steps_taken}, 4'h0);
    rst = 1'b1;

    // One step, order A: 00 -> 10
    waitCycle();
    applyStimulus(1'b1, 2'b10, 1'b0);
    waitCycle();
    applyStimulus(1'b0, 2'b00, 1'b0);
    checkOutput("t1_step_e0", {3'b0, bus.step}, 4'h1);
    checkOutput("t1_busy_e0", {3'b0, bus.busy}, 4'h1);
    checkOutput("t1_count_e0", {2'b0, bus.count}, 4'h0);
    waitCycle();
    checkOutput("t1_step_e1", {3'b0, bus.step}, 4'h0);
    checkOutput("t1_done_e1", {3'b0, bus.done}, 4'h1);
    checkOutput("t1_count_e1", {2'b0, bus.count}, 4'h2);
    checkOutput("t1_steps_e1", {2'b0, bus.steps_taken}, 4'h1);
    waitCycle();
    checkOutput("t1_busy_e2", {3'b0, bus.busy}, 4'h0);
    checkOutput("t1_done_e2", {3'b0, bus.done}, 4'h0);
    checkOutput("t1_steps_hold", {2'b0, bus.steps_taken}, 4'h1);

    // Three steps, order A: 00 -> 10 -> 11 -> 01
    doReset();
    applyStimulus(1'b1, 2'b01, 1'b0);
    waitCycle();
    applyStimulus(1'b0, 2'b00, 1'b0);
    checkOutput("t2_step_e0", {3'b0, bus.step}, 4'h1);
    waitCycle();
    checkOutput("t2_count_e1", {2'b0, bus.count}, 4'h2);
    checkOutput("t2_step_e1", {3'b0, bus.step}, 4'h1);
    waitCycle();
    checkOutput("t2_count_e2", {2'b0, bus.count}, 4'h3);
    checkOutput("t2_step_e2", {3'b0, bus.step}, 4'h1);
    waitCycle();
    checkOutput("t2_count_e3", {2'b0, bus.count}, 4'h1);
    checkOutput("t2_step_e3", {3'b0, bus.step}, 4'h0);
    checkOutput("t2_done_e3", {3'b0, bus.done}, 4'h1);
    checkOutput("t2_steps_e3", {2'b0, bus.steps_taken}, 4'h3);
    waitCycle();
    checkOutput("t2_busy_e4", {3'b0, bus.busy}, 4'h0);

    // Two steps, order B: 00 -> 11 -> 10, then a zero-step request
    doReset();
    applyStimulus(1'b1, 2'b10, 1'b1);
    waitCycle();
    applyStimulus(1'b0, 2'b00, 1'b0);
    waitCycle();
    checkOutput("t3_count_e1", {2'b0, bus.count}, 4'h3);
    checkOutput("t3_step_e1", {3'b0, bus.step}, 4'h1);
    waitCycle();
    checkOutput("t3_count_e2", {2'b0, bus.count}, 4'h2);
    checkOutput("t3_done_e2", {3'b0, bus.done}, 4'h1);
    checkOutput("t3_steps_e2", {2'b0, bus.steps_taken}, 4'h2);
    waitCycle();
    applyStimulus(1'b1, 2'b10, 1'b1);
    waitCycle();
    applyStimulus(1'b0, 2'b00, 1'b0);
    checkOutput("t3z_done", {3'b0, bus.done}, 4'h1);
    checkOutput("t3z_step", {3'b0, bus.step}, 4'h0);
    checkOutput("t3z_steps", {2'b0, bus.steps_taken}, 4'h0);
    checkOutput("t3z_count", {2'b0, bus.count}, 4'h2);
    waitCycle();
    checkOutput("t3z_idle", {3'b0, bus.busy}, 4'h0);

    // Held req from 10: first run 10 -> 11 -> 01 (A), inputs changed while busy,
    // second run picks up target 00 order B: 01 -> 00
    applyStimulus(1'b1, 2'b01, 1'b0);
    waitCycle();
    applyStimulus(1'b1, 2'b00, 1'b1);
    checkOutput("t4_step_e0", {3'b0, bus.step}, 4'h1);
    waitCycle();
    checkOutput("t4_count_e1", {2'b0, bus.count}, 4'h3);
    checkOutput("t4_step_e1", {3'b0, bus.step}, 4'h1);
    waitCycle();
    checkOutput("t4_count_e2", {2'b0, bus.count}, 4'h1);
    checkOutput("t4_done_e2", {3'b0, bus.done}, 4'h1);
    checkOutput("t4_steps_e2", {2'b0, bus.steps_taken}, 4'h2);
    waitCycle();
    checkOutput("t4_busy_e3", {3'b0, bus.busy}, 4'h0);
    checkOutput("t4_done_e3", {3'b0, bus.done}, 4'h0);
    waitCycle();
    applyStimulus(1'b0, 2'b11, 1'b0);
    checkOutput("t4_step_e4", {3'b0, bus.step}, 4'h1);
    checkOutput("t4_steps_e4", {2'b0, bus.steps_taken}, 4'h0);
    waitCycle();
    checkOutput("t4_count_e5", {2'b0, bus.count}, 4'h0);
    checkOutput("t4_done_e5", {3'b0, bus.done}, 4'h1);
    checkOutput("t4_steps_e5", {2'b0, bus.steps_taken}, 4'h1);
    waitCycle();
    checkOutput("t4_busy_e6", {3'b0, bus.busy}, 4'h0);

    // Reset pulled while stepping at count 11
    doReset();
    applyStimulus(1'b1, 2'b01, 1'b0);
    waitCycle();
    applyStimulus(1'b0, 2'b00, 1'b0);
    waitCycle();
    waitCycle();
    checkOutput("t5_count_pre", {2'b0, bus.count}, 4'h3);
    checkOutput("t5_step_pre", {3'b0, bus.step}, 4'h1);
    rst = 1'b0;
    #1;
    checkOutput("t5_count_rst", {2'b0, bus.count}, 4'h0);
    checkOutput("t5_busy_rst", {3'b0, bus.busy}, 4'h0);
    checkOutput("t5_done_rst", {3'b0, bus.done}, 4'h0);
    checkOutput("t5_steps_rst", {2'b0, bus.steps_taken}, 4'h0);
    waitCycle();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      waitCycle();
      checkOutput("t5_done_after", {3'b0, bus.done}, 4'h0);
      checkOutput("t5_busy_after", {3'b0, bus.busy}, 4'h0);
      checkOutput("t5_count_after", {2'b0, bus.count}, 4'h0);
    end

`ifdef SEQ_STEP_ABORT_EN
    // Abort on the second STEP cycle: only 00 -> 10 happens
    applyStimulus(1'b1, 2'b01, 1'b0);
    waitCycle();
    applyStimulus(1'b0, 2'b00, 1'b0);
    waitCycle();
    checkOutput("t6_count_e1", {2'b0, bus.count}, 4'h2);
    checkOutput("t6_step_e1", {3'b0, bus.step}, 4'h1);
    bus.abort = 1'b1;
    waitCycle();
    bus.abort = 1'b0;
    checkOutput("t6_count_e2", {2'b0, bus.count}, 4'h2);
    checkOutput("t6_done_e2", {3'b0, bus.done}, 4'h1);
    checkOutput("t6_steps_e2", {2'b0, bus.steps_taken}, 4'h1);
    waitCycle();
    checkOutput("t6_busy_e3", {3'b0, bus.busy}, 4'h0);
    checkOutput("t6_count_e3", {2'b0, bus.count}, 4'h2);
`endif

    $display("[TB] directed sequence complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
